serial_subtractor: RTL

Bit-serial two's-complement subtractor computing `minuend - subtrahend` one bit per clock, LSB first, through a single borrow flip-flop. It is the inverse companion of the combinational ripple-carry adder in the CORDIC datapath. The CORDIC sequencer uses it for the subtract-direction micro-rotations, and also wherever area matters more than latency on the TinyTapeout tile. Operation is start/done handshaked, and results are held until the next operation completes.

---
 rtl/serial_subtractor.sv | 130 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
`timescale 1ns/1ps
// serial_subtractor
// Bit-serial two's-complement subtractor: diff = minuend - subtrahend,
// one bit per clock, LSB first, through a single borrow flip-flop.
// Results are registered and held until the next operation completes.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   start       request, sampled only in IDLE
//   minuend     operand A, captured on the accepting edge
//   subtrahend  operand B, captured on the accepting edge
//   busy        high in SHIFT and DONE
//   done        one-cycle pulse when results become valid
//   diff        A - B modulo 2^bits
//   borrow_out  unsigned underflow (A < B)
//   overflow    signed overflow of A - B
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one difference bit per cycle, bits cycles
// DONE  | results visible, done pulses
module serial_subtractor #(
  parameter int bits = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [bits-1:0] minuend,
  input  logic [bits-1:0] subtrahend,
  output logic            busy,
  output logic            done,
  output logic [bits-1:0] diff,
  output logic            borrow_out,
  output logic            overflow
);

  localparam int CW = (bits > 1) ? $clog2(bits) : 1;
  localparam logic [CW-1:0] LAST = CW'(bits - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [bits-1:0] a_reg;
  logic [bits-1:0] b_reg;
  logic [bits-1:0] res_reg;
  logic            borrow_q;
  logic [CW-1:0]   cnt;
  logic            a_msb;
  logic            b_msb;

  logic            a0;
  logic            b0;
  logic            d_bit;
  logic            borrow_nxt;
  logic [bits-1:0] res_nxt;

  always_comb begin
    a0         = a_reg[0];
    b0         = b_reg[0];
    d_bit      = a0 ^ b0 ^ borrow_q;
    borrow_nxt = (~a0 & b0) | (~(a0 ^ b0) & borrow_q);
    res_nxt    = {d_bit, res_reg[bits-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Outputs are loaded on the final shift edge so they are already visible
  // during the DONE cycle; the partially built result never reaches diff.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      borrow_q   <= 1'b0;
      cnt        <= '0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg    <= minuend;
            b_reg    <= subtrahend;
            a_msb    <= minuend[bits-1];
            b_msb    <= subtrahend[bits-1];
            res_reg  <= '0;
            borrow_q <= 1'b0;
            cnt      <= '0;
          end
        end
        SHIFT: begin
          a_reg    <= a_reg >> 1;
          b_reg    <= b_reg >> 1;
          res_reg  <= res_nxt;
          borrow_q <= borrow_nxt;
          cnt      <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff       <= res_nxt;
            borrow_out <= borrow_nxt;
            // d_bit is the result MSB on the last shift
            overflow   <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
